fifo_burst_reader: RTL
======================

// Module: fifo_burst_reader
// PURPOSE
//  Consumer end of the flip-flop FIFO push/pop interface: on a start command, pops a burst
//  of burst_len words from a show-ahead FIFO (read_data valid while !empty) and delivers them
//  on a valid/ready output stream through a registered output stage. Sits between a FIFO's
//  read side and a downstream sink. Signals completion with a one-cycle done pulse.
// PARAMETERS
//  width      8  data word width, equal to the FIFO width
//  len_width  8  width of burst_len and the internal remaining/delivered counters
// PORTS
//  clk         in   1          clock, all state on rising edge
//  rst         in   1          asynchronous, active-low reset (asserted when 0)
//  start       in   1          start a burst; sampled only in IDLE
//  burst_len   in   len_width  words in the burst, sampled with start
//  busy        out  1          1 from the cycle after accepted start until done
//  done        out  1          one-cycle pulse when last word accepted downstream
//  fifo_empty  in   1          FIFO empty flag
//  fifo_rdata  in   width      FIFO head word, valid when fifo_empty==0
//  fifo_pop    out  1          pop strobe to FIFO
//  out_valid   out  1          out_data holds a word
//  out_ready   in   1          downstream accepts when out_valid & out_ready
//  out_data    out  width      registered output word
// BEHAVIOUR
//  - Reset (rst==0, async): state=IDLE; busy=0, done=0, fifo_pop=0, out_valid=0, out_data=0,
//    counters=0. Mid-burst reset abandons the burst; a popped-but-undelivered word is lost.
//  - States: IDLE -> READ (start & burst_len!=0); IDLE -> DONE (start & burst_len==0);
//    READ -> DRAIN when the last pop occurs (remaining 1->0); DRAIN -> DONE when the last
//    word is accepted; DONE -> IDLE unconditionally. done=1 only in DONE (1 cycle).
//  - READ pops on the same cycle the last word is accepted may complete READ->DRAIN->DONE
//    path: if last pop and no word outstanding is impossible; DRAIN always lasts >=1 cycle.
//  - start outside IDLE ignored; burst_len latched into remaining at accepted start.
//  - fifo_pop (combinational) = (state==READ) & !fifo_empty & (remaining!=0)
//    & (!out_valid | out_ready). Never asserted while fifo_empty==1.
//  - On fifo_pop: out_data <= fifo_rdata, out_valid <= 1, remaining <= remaining-1.
//    Else if out_valid & out_ready: out_valid <= 0. Latency FIFO head -> out_data: 1 cycle.
//  - Throughput: one word/cycle while out_ready=1 and FIFO non-empty (pop and accept same cycle).
//  - out_data holds stable while out_valid & !out_ready; out_valid never drops without accept.
//  - FIFO empty mid-burst: stall in READ, no pop, out_valid drops after pending accept.
//  - delivered counter increments on each accept, wraps modulo 2**len_width; cleared at start.
//  - busy=1 in READ and DRAIN, 0 in IDLE and DONE.
// STRUCTURE
//  - Package fifo_reader_pkg: typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t.
//  - One sub-module natural: vr_out_reg (width param) — single-entry valid/ready output
//    register with load/accept; FSM, counters and pop logic stay in fifo_burst_reader.
// TESTING
//  1 reset with rst=0 mid-burst (len=5 after 2 pops) -> all outputs 0 next edge, state IDLE.
//  2 FIFO holds 0x11..0x14, start len=4, out_ready=1 -> 4 pops in 4 consecutive cycles,
//    out_data 0x11,0x12,0x13,0x14 each 1 cycle after its pop, done pulse once, busy back to 0.
//  3 len=3, out_ready=0 for 5 cycles after first word -> exactly 1 pop, out_data stable,
//    no further pops until out_ready=1; all 3 words delivered in order.
//  4 start len=4 with FIFO holding 2 words, 3rd word pushed 6 cycles later -> stall in READ,
//    no pop while empty, burst completes after 3rd and 4th word arrive.
//  5 start len=0 -> no fifo_pop, out_valid stays 0, done pulse 1 cycle later.
//  6 start pulsed while busy (len=7 during len=2 burst) -> ignored, exactly 2 words popped.

Source files
------------

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and default widths for the FIFO burst reader.
package fifo_reader_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read-side and valid/ready output stream seen by the burst reader.
interface fifo_burst_reader_if
  import fifo_reader_pkg::*;
#(
  parameter int unsigned width = DEF_WIDTH
);

  logic             fifo_empty;
  logic [width-1:0] fifo_rdata;
  logic             fifo_pop;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;

  // Reader side: consumes the FIFO, drives the output stream
  modport master (
    input  fifo_empty, fifo_rdata, out_ready,
    output fifo_pop, out_valid, out_data
  );

  // Environment side: FIFO plus downstream sink
  modport slave (
    output fifo_empty, fifo_rdata, out_ready,
    input  fifo_pop, out_valid, out_data
  );

endinterface

// File: rtl/fifo_burst_reader_vr_out_reg.sv
// Single-entry valid/ready output register: load wins over accept.
module vr_out_reg #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a burst of burst_len words from a show-ahead FIFO and streams them
// out through a registered valid/ready stage, pulsing done at the end.
module fifo_burst_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned width     = DEF_WIDTH,
  parameter int unsigned len_width = DEF_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [len_width-1:0] burst_len,
  output logic                 busy,
  output logic                 done,
  fifo_burst_reader_if.master  bus
);

  state_t               state;
  state_t               state_nxt;
  logic [len_width-1:0] remaining;
  logic [len_width-1:0] delivered;
  logic [len_width-1:0] len_q;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic                 pop;
  logic                 accept;
  logic                 last_pop;
  logic                 last_accept;
  logic                 start_ok;

  // Pop only when the output slot is free or being emptied this cycle
  assign pop = (state == READ) && !bus.fifo_empty && (remaining != '0)
               && (!bus.out_valid || bus.out_ready);
  assign accept      = bus.out_valid && bus.out_ready;
  assign last_pop    = pop && (remaining == len_width'(1));
  assign last_accept = accept && ((delivered + len_width'(1)) == len_q);
  assign start_ok    = (state == IDLE) && start;
  assign bus.fifo_pop = pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (burst_len == '0) ? DONE : READ;
      READ:    if (last_pop) state_nxt = DRAIN;
      DRAIN:   if (last_accept) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == READ) || (state_nxt == DRAIN);
    done_nxt = (state_nxt == DONE);
  end

  // Burst bookkeeping: words still to pop and words handed downstream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
      delivered <= '0;
      len_q     <= '0;
    end else if (start_ok) begin
      remaining <= burst_len;
      delivered <= '0;
      len_q     <= burst_len;
    end else begin
      if (pop)    remaining <= remaining - len_width'(1);
      if (accept) delivered <= delivered + len_width'(1);
    end
  end

  vr_out_reg #(
    .width (width)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (pop),
    .load_data (bus.fifo_rdata),
    .ready     (bus.out_ready),
    .valid     (bus.out_valid),
    .data      (bus.out_data)
  );

endmodule
